// File: rtl/instr_split_stage_if.sv
// Instruction-in / decoded-fields-out bundle for instr_split_stage; the stage takes the
// slave side, the fetch/regfile environment the master side. Valid/ready on both edges.
interface instr_split_stage_if #(
    parameter int OPCODE_W = 4,
    parameter int REG_W    = 3,
    parameter int FUNCT_W  = 3,
    parameter int IMM_W    = 6,
    parameter int DATA_W   = 16,
    parameter int INSTR_W  = OPCODE_W + 3*REG_W + FUNCT_W
);
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [FUNCT_W-1:0]  funct;
    logic [IMM_W-1:0]    immed;
    logic [DATA_W-1:0]   imm_ext;
    logic                is_rtype;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_instr, opcode, rs, rt, rd, funct, immed, imm_ext, is_rtype
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_instr, opcode, rs, rt, rd, funct, immed, imm_ext, is_rtype
    );
endinterface

// File: rtl/instr_split_stage.sv
// Registered instruction splitter with 2-entry skid buffer: fields valid 1 cycle after accept,
// in_ready comes from registered state only. SPLIT_STATS_EN adds saturating R-type/other counters.
module instr_split_stage #(
    parameter int OPCODE_W = 4,
    parameter int REG_W    = 3,
    parameter int FUNCT_W  = 3,
    parameter int IMM_W    = 6,
    parameter int DATA_W   = 16,
    parameter int INSTR_W  = OPCODE_W + 3*REG_W + FUNCT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    instr_split_stage_if.slave  bus
`ifdef SPLIT_STATS_EN
    ,
    output logic [15:0]         rtype_count,
    output logic [15:0]         other_count
`endif
);

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] out_q, out_d;
    logic [INSTR_W-1:0] skid_q, skid_d;
    logic               in_fire;
    logic               out_fire;

    // in_ready is forced low while reset is asserted so nothing is taken during reset.
    assign bus.in_ready  = !reset && (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        out_d   = bus.in_instr;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        out_d = bus.in_instr;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = bus.in_instr;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        out_d   = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.out_instr = out_q;
    assign bus.opcode    = out_q[INSTR_W-1 -: OPCODE_W];
    assign bus.rs        = out_q[INSTR_W-OPCODE_W-1 -: REG_W];
    assign bus.rt        = out_q[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
    assign bus.rd        = out_q[FUNCT_W +: REG_W];
    assign bus.funct     = out_q[FUNCT_W-1:0];
    assign bus.immed     = out_q[IMM_W-1:0];
    assign bus.imm_ext   = DATA_W'($signed(out_q[IMM_W-1:0]));
    assign bus.is_rtype  = (out_q[INSTR_W-1 -: OPCODE_W] == '0);

`ifdef SPLIT_STATS_EN
    logic [15:0] rtype_q, rtype_d;
    logic [15:0] other_q, other_d;

    // A word delivered in a flush cycle still counts; flush never clears the counters.
    always_comb begin
        rtype_d = rtype_q;
        other_d = other_q;
        if (out_fire) begin
            if (bus.is_rtype) begin
                if (rtype_q != 16'hFFFF) rtype_d = rtype_q + 16'd1;
            end else begin
                if (other_q != 16'hFFFF) other_d = other_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rtype_q <= '0;
            other_q <= '0;
        end else begin
            rtype_q <= rtype_d;
            other_q <= other_d;
        end
    end

    assign rtype_count = rtype_q;
    assign other_count = other_q;
`endif

endmodule
